axi_byte_verify_engine: RTL
===========================

// Module: axi_byte_verify_engine
// PURPOSE
//  Parametrised byte-verification engine for the AXI4 byte-access testbench. Accepts a stream of
//  (addr, expected_byte, test_count) entries, issues single-beat AXI4 reads, extracts the addressed
//  byte lane, and compares it against the expected value. Multiple reads may be outstanding.
//  Reports pass/fail counts, first-mismatch capture and a phase start/done handshake to the top TB.
// PARAMETERS
//  AXI_ADDR_WIDTH   32  address width
//  AXI_DATA_WIDTH   32  read data width; power of 2, 8..1024; DATA_BYTES = AXI_DATA_WIDTH/8
//  AXI_ID_WIDTH     8   ARID/RID width
//  MAX_OUTSTANDING  4   maximum in-flight reads; power of 2, 1..16; sizes the pending FIFO
//  ARID_VALUE       0   fixed ARID; all reads use one ID, so R returns in order
// PORTS
//  clk              in   1               clock
//  rst_n            in   1               asynchronous active-low reset
//  phase_start      in   1               1-cycle pulse: begin phase (ignored unless IDLE)
//  clear_done       in   1               clears done_latched, returns FINISH -> IDLE
//  ent_valid        in   1               entry valid
//  ent_ready        out  1               entry accepted when ent_valid&&ent_ready
//  ent_addr         in   AXI_ADDR_WIDTH  byte address to verify
//  ent_expected     in   8               expected byte value
//  ent_test_count   in   32              test tag, carried to mismatch capture
//  ent_last         in   1               marks final entry of the phase
//  araddr/arid/arlen/arsize/arburst  out  ADDR/ID/8/3/2  AR channel payload
//  arvalid out 1 / arready in 1          AR handshake
//  rdata in DATA / rid in ID / rresp in 2 / rlast in 1 / rvalid in 1 / rready out 1   R channel
//  phase_busy       out  1               high in ACTIVE and DRAIN
//  phase_done       out  1               high in FINISH
//  done_latched     out  1               sticky done, cleared by clear_done
//  pass_count       out  32              matching bytes
//  fail_count       out  32              mismatches plus non-OKAY responses
//  err_valid        out  1               sticky: first failure captured
//  err_addr/err_expected/err_actual/err_test_count out ADDR/8/8/32  first-failure record
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (arvalid, rready, ent_ready, counts, err_*, done flags); FIFO empty.
//  States: IDLE -phase_start-> ACTIVE (clears counts, err_*, FIFO). ACTIVE -last entry accepted-> DRAIN.
//   DRAIN -FIFO empty && !arvalid-> FINISH. FINISH -clear_done-> IDLE. Other states -> IDLE.
//  AR: arlen=0, arsize=0 (1 byte), arburst=INCR(01), arid=ARID_VALUE, araddr=entry addr unaligned.
//   ent_ready = ACTIVE && (!arvalid || arready) && pending_cnt_after_issue < MAX_OUTSTANDING.
//   Accept registers araddr and asserts arvalid next cycle; arvalid/araddr held stable until arready.
//   On accept, push {lane=addr[log2(DATA_BYTES)-1:0], expected, addr, test_count} into pending FIFO.
//  R: rready=1 whenever FIFO non-empty (ACTIVE/DRAIN). On rvalid&&rready pop FIFO head;
//   actual = rdata[8*lane +: 8]. Pass iff rresp==2'b00 && actual==expected && rid==ARID_VALUE
//   && rlast==1. Otherwise fail; compare result registered, counters update 1 cycle after R beat.
//  Simultaneous accept and R pop in one cycle: pending count unchanged, FIFO push+pop both occur.
//  R beat with FIFO empty: ignored (rready low), no count change.
//  err_*: loaded on first fail only; later fails increment fail_count but do not overwrite.
//  Counters saturate at 32'hFFFF_FFFF. DATA_BYTES==1: lane is constant 0.
//  phase_start outside IDLE ignored. ent_last entry is issued like any other; phase with zero
//   entries is not supported (first accepted entry must be present; bench always sends >=1).
//  done_latched sets on entry to FINISH; clear_done takes priority over set in the same cycle.
//  Reset mid-phase: immediate return to IDLE, FIFO flushed, arvalid/rready drop asynchronously;
//   in-flight AXI transactions are abandoned (interconnect must also be reset).
//  Latency: ent accept -> arvalid 1 cycle; R beat -> count update 1 cycle; last R -> phase_done 2 cycles.
// TESTING
//  1 DATA=32: entries 0x100/AA,0x101/BB,0x102/CC,0x103/DD(last), memory matches -> pass=4, fail=0, phase_done.
//  2 Entry 0x205 exp 0x11, rdata=0x0000_2200 -> fail=1, err_addr=0x205, err_actual=0x22, err_expected=0x11.
//  3 MAX_OUTSTANDING=4, arready=1, R delayed 20 cycles, 8 entries -> exactly 4 in flight, ent_ready low at 4.
//  4 rresp=SLVERR on 2nd of 3 matching reads -> pass=2, fail=1, err_valid captures 2nd entry.
//  5 DATA=128: addr 0x100F exp 0x5A, rdata[127:120]=0x5A -> pass=1; arvalid held with arready low 5 cycles.
//  6 rst_n low with 3 reads pending, then phase_start -> counts 0, FIFO empty, new phase completes normally.

Source files
------------

// File: rtl/axi_byte_verify_engine.sv
// Byte-verification engine: issues single-byte AXI4 reads for a stream of entries and checks
// the returned lane against the expected byte, tracking pass/fail counts and the first failure.
module axi_byte_verify_engine #(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_ID_WIDTH    = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ARID_VALUE      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      phase_start,
    input  logic                      clear_done,
    input  logic                      ent_valid,
    output logic                      ent_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] ent_addr,
    input  logic [7:0]                ent_expected,
    input  logic [31:0]               ent_test_count,
    input  logic                      ent_last,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [AXI_ID_WIDTH-1:0]   arid,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic [AXI_ID_WIDTH-1:0]   rid,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic                      phase_busy,
    output logic                      phase_done,
    output logic                      done_latched,
    output logic [31:0]               pass_count,
    output logic [31:0]               fail_count,
    output logic                      err_valid,
    output logic [AXI_ADDR_WIDTH-1:0] err_addr,
    output logic [7:0]                err_expected,
    output logic [7:0]                err_actual,
    output logic [31:0]               err_test_count
);

    localparam int unsigned DataBytes = AXI_DATA_WIDTH / 8;
    localparam int unsigned LaneW     = (DataBytes > 1) ? $clog2(DataBytes) : 1;
    localparam int unsigned PtrW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW      = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [AXI_ID_WIDTH-1:0] ArId    = AXI_ID_WIDTH'(ARID_VALUE);
    localparam logic [PtrW-1:0]         LastPtr = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [CntW-1:0]         MaxCnt  = CntW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StFinish} state_e;

    state_e state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0] fifo_addr [MAX_OUTSTANDING];
    logic [7:0]                fifo_exp  [MAX_OUTSTANDING];
    logic [31:0]               fifo_tc   [MAX_OUTSTANDING];
    logic [LaneW-1:0]          fifo_lane [MAX_OUTSTANDING];
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]           cnt_q;

    logic                      arvalid_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;

    logic                      res_valid_q, res_pass_q;
    logic [AXI_ADDR_WIDTH-1:0] res_addr_q;
    logic [7:0]                res_exp_q, res_actual_q;
    logic [31:0]               res_tc_q;

    logic [31:0]               pass_q, fail_q;
    logic                      err_valid_q, done_q;
    logic [AXI_ADDR_WIDTH-1:0] err_addr_q;
    logic [7:0]                err_exp_q, err_actual_q;
    logic [31:0]               err_tc_q;

    logic             clear, accept, pop, pass_now;
    logic [LaneW-1:0] lane_in, head_lane;
    logic [7:0]       actual;

    assign clear  = (state_q == StIdle) && phase_start;
    assign accept = ent_valid && ent_ready;
    assign pop    = rvalid && rready;

    assign lane_in   = (DataBytes > 1) ? ent_addr[LaneW-1:0] : '0;
    assign head_lane = fifo_lane[rd_ptr_q];
    assign actual    = rdata[{head_lane, 3'b000} +: 8];
    assign pass_now  = (rresp == 2'b00) && (actual == fifo_exp[rd_ptr_q]) && (rid == ArId) && rlast;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (phase_start) state_d = StActive;
            StActive: if (accept && ent_last) state_d = StDrain;
            // Wait for the last result to land in the counters before reporting done
            StDrain:  if (cnt_q == '0 && !arvalid_q && !res_valid_q) state_d = StFinish;
            StFinish: if (clear_done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        phase_busy = 1'b0;
        phase_done = 1'b0;
        ent_ready  = 1'b0;
        rready     = 1'b0;
        unique case (state_q)
            StActive: begin
                phase_busy = 1'b1;
                ent_ready  = (!arvalid_q || arready) && (cnt_q < MaxCnt);
                rready     = (cnt_q != '0);
            end
            StDrain: begin
                phase_busy = 1'b1;
                rready     = (cnt_q != '0);
            end
            StFinish: phase_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_addr[wr_ptr_q] <= ent_addr;
            fifo_exp[wr_ptr_q]  <= ent_expected;
            fifo_tc[wr_ptr_q]   <= ent_test_count;
            fifo_lane[wr_ptr_q] <= lane_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            if (accept && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !accept) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Accept is only possible when the AR slot is free or draining this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
        end else if (accept) begin
            arvalid_q <= 1'b1;
            araddr_q  <= ent_addr;
        end else if (arready) begin
            arvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_pass_q   <= 1'b0;
            res_addr_q   <= '0;
            res_exp_q    <= '0;
            res_actual_q <= '0;
            res_tc_q     <= '0;
        end else begin
            res_valid_q <= pop;
            if (pop) begin
                res_pass_q   <= pass_now;
                res_addr_q   <= fifo_addr[rd_ptr_q];
                res_exp_q    <= fifo_exp[rd_ptr_q];
                res_actual_q <= actual;
                res_tc_q     <= fifo_tc[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q       <= '0;
            fail_q       <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_exp_q    <= '0;
            err_actual_q <= '0;
            err_tc_q     <= '0;
        end else if (clear) begin
            pass_q       <= '0;
            fail_q       <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_exp_q    <= '0;
            err_actual_q <= '0;
            err_tc_q     <= '0;
        end else if (res_valid_q) begin
            if (res_pass_q) begin
                if (pass_q != '1) pass_q <= pass_q + 32'd1;
            end else begin
                if (fail_q != '1) fail_q <= fail_q + 32'd1;
                if (!err_valid_q) begin
                    err_valid_q  <= 1'b1;
                    err_addr_q   <= res_addr_q;
                    err_exp_q    <= res_exp_q;
                    err_actual_q <= res_actual_q;
                    err_tc_q     <= res_tc_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (clear_done) begin
            done_q <= 1'b0;
        end else if (state_d == StFinish && state_q != StFinish) begin
            done_q <= 1'b1;
        end
    end

    assign araddr         = araddr_q;
    assign arvalid        = arvalid_q;
    assign arid           = ArId;
    assign arlen          = 8'd0;
    assign arsize         = 3'd0;
    assign arburst        = 2'b01;
    assign done_latched   = done_q;
    assign pass_count     = pass_q;
    assign fail_count     = fail_q;
    assign err_valid      = err_valid_q;
    assign err_addr       = err_addr_q;
    assign err_expected   = err_exp_q;
    assign err_actual     = err_actual_q;
    assign err_test_count = err_tc_q;

endmodule
